// File: rtl/instruction_fetch.sv
// Fetch stage: single-outstanding instruction memory reads feeding a 2-entry output FIFO.
// Optional FETCH_ALIGN_CHECK_EN turns misaligned fetches into flagged NOP entries.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | no outstanding read; may issue a request
// WAIT   | read granted, awaiting mem_rvalid_i
// DROP   | flushed read still in flight; data discarded
module instruction_fetch #(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int INSTR_WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [MEM_ADDR_WIDTH-1:0] pc_i,
    input  logic                      pc_valid_i,
    output logic                      pc_ready_o,
    input  logic                      flush_i,
    output logic                      mem_req_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    input  logic [INSTR_WIDTH-1:0]    mem_rdata_i,
    output logic [INSTR_WIDTH-1:0]    instr_o,
    output logic [MEM_ADDR_WIDTH-1:0] instr_pc_o,
    output logic                      instr_valid_o,
    input  logic                      instr_ready_i,
    output logic                      misalign_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_e;

    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = INSTR_WIDTH'(32'h0000_0013);

    state_e                    state_q;
    logic [MEM_ADDR_WIDTH-1:0] req_pc_q;

    logic [1:0]                count_q, count_d;
    logic [INSTR_WIDTH-1:0]    head_instr_q, head_instr_d;
    logic [INSTR_WIDTH-1:0]    tail_instr_q, tail_instr_d;
    logic [MEM_ADDR_WIDTH-1:0] head_pc_q, head_pc_d;
    logic [MEM_ADDR_WIDTH-1:0] tail_pc_q, tail_pc_d;
    logic                      head_mis_q, head_mis_d;
    logic                      tail_mis_q, tail_mis_d;

    logic                      is_idle;
    logic                      has_space;
    logic                      misaligned;
    logic                      req_fire;
    logic                      mis_fire;
    logic                      mem_push;
    logic                      push;
    logic                      pop;
    logic [MEM_ADDR_WIDTH-1:0] issue_addr;
    logic [INSTR_WIDTH-1:0]    push_instr;
    logic [MEM_ADDR_WIDTH-1:0] push_pc;
    logic                      push_mis;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = pc_valid_i && (pc_i[1:0] != 2'b00);
    assign issue_addr = pc_i;
`else
    assign misaligned = 1'b0;
    assign issue_addr = {pc_i[MEM_ADDR_WIDTH-1:2], 2'b00};
`endif

    assign is_idle    = (state_q == S_IDLE);
    assign has_space  = (count_q < 2'd2);

    assign mem_req_o  = pc_valid_i && is_idle && !flush_i && has_space && !misaligned;
    assign mem_addr_o = issue_addr;
    assign pc_ready_o = is_idle && !flush_i && has_space && (mem_gnt_i || misaligned);

    assign req_fire   = mem_req_o && mem_gnt_i;
    assign mis_fire   = misaligned && pc_ready_o;
    assign mem_push   = (state_q == S_WAIT) && mem_rvalid_i && !flush_i;
    assign push       = mem_push || mis_fire;
    assign pop        = instr_valid_o && instr_ready_i;

    // Memory data and misalign NOPs can never collide: one needs WAIT, the other IDLE.
    assign push_instr = mem_push ? mem_rdata_i : NOP_INSTR;
    assign push_pc    = mem_push ? req_pc_q    : pc_i;
    assign push_mis   = !mem_push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            req_pc_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_fire) begin
                        state_q  <= S_WAIT;
                        req_pc_q <= issue_addr;
                    end
                end
                S_WAIT: begin
                    if (flush_i) begin
                        state_q <= mem_rvalid_i ? S_IDLE : S_DROP;
                    end else if (mem_rvalid_i) begin
                        state_q <= S_IDLE;
                    end
                end
                S_DROP: begin
                    if (mem_rvalid_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Shift-style FIFO: head registers drive the outputs directly.
    always_comb begin
        count_d      = count_q;
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        head_mis_d   = head_mis_q;
        tail_instr_d = tail_instr_q;
        tail_pc_d    = tail_pc_q;
        tail_mis_d   = tail_mis_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_instr_d = push_instr;
                        head_pc_d    = push_pc;
                        head_mis_d   = push_mis;
                    end else begin
                        tail_instr_d = push_instr;
                        tail_pc_d    = push_pc;
                        tail_mis_d   = push_mis;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_instr_d = tail_instr_q;
                    head_pc_d    = tail_pc_q;
                    head_mis_d   = tail_mis_q;
                    count_d      = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_instr_d = push_instr;
                        head_pc_d    = push_pc;
                        head_mis_d   = push_mis;
                    end else begin
                        head_instr_d = tail_instr_q;
                        head_pc_d    = tail_pc_q;
                        head_mis_d   = tail_mis_q;
                        tail_instr_d = push_instr;
                        tail_pc_d    = push_pc;
                        tail_mis_d   = push_mis;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= 2'd0;
            head_instr_q <= '0;
            head_pc_q    <= '0;
            head_mis_q   <= 1'b0;
            tail_instr_q <= '0;
            tail_pc_q    <= '0;
            tail_mis_q   <= 1'b0;
        end else begin
            count_q      <= count_d;
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
            head_mis_q   <= head_mis_d;
            tail_instr_q <= tail_instr_d;
            tail_pc_q    <= tail_pc_d;
            tail_mis_q   <= tail_mis_d;
        end
    end

    assign instr_valid_o = (count_q != 2'd0);
    assign instr_o       = head_instr_q;
    assign instr_pc_o    = head_pc_q;
    assign misalign_o    = head_mis_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: queue-based reference model checked every cycle,
// plus literal expectations at the points the stimulus is built around.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  pc = '0;
    logic        pc_valid = 1'b0;
    logic        pc_ready;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [9:0]  mem_addr;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic [31:0] instr;
    logic [9:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        misalign;

    int total = 0;
    int bad   = 0;

    instruction_fetch #(.MEM_ADDR_WIDTH(10), .INSTR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .pc_i(pc), .pc_valid_i(pc_valid), .pc_ready_o(pc_ready),
        .flush_i(flush), .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(gnt),
        .mem_rvalid_i(rvalid), .mem_rdata_i(rdata), .instr_o(instr), .instr_pc_o(instr_pc),
        .instr_valid_o(instr_valid), .instr_ready_i(instr_ready), .misalign_o(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of buffered entries and the status of the one outstanding read.
    typedef struct packed {
        logic [31:0] instr;
        logic [9:0]  pc;
        logic        mis;
    } ent_t;

    ent_t       mq[$];
    int         m_out = 0;   // 0 none, 1 live read, 2 read to discard
    logic [9:0] m_pc = '0;
    bit         mp_pop, mp_req, mp_mis;
    ent_t       m_e;

    function automatic logic m_misaligned();
`ifdef FETCH_ALIGN_CHECK_EN
        return pc_valid && (pc[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [9:0] exp_addr();
`ifdef FETCH_ALIGN_CHECK_EN
        return pc;
`else
        return {pc[9:2], 2'b00};
`endif
    endfunction

    function automatic logic exp_req();
        return pc_valid && (m_out == 0) && !flush && (mq.size() < 2) && !m_misaligned();
    endfunction

    function automatic logic exp_rdy();
        return (m_out == 0) && !flush && (mq.size() < 2) && (gnt || m_misaligned());
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_out = 0;
        end else begin
            mp_pop = (mq.size() != 0) && instr_ready;
            mp_req = exp_req() && gnt;
            mp_mis = exp_rdy() && m_misaligned();
            if (flush) begin
                mq.delete();
                if (m_out == 1) m_out = rvalid ? 0 : 2;
                else if (m_out == 2 && rvalid) m_out = 0;
            end else begin
                if (mp_pop) mq.delete(0);
                if (m_out == 0) begin
                    if (mp_req) begin
                        m_out = 1;
                        m_pc  = exp_addr();
                    end else if (mp_mis) begin
                        m_e.instr = NOP; m_e.pc = pc; m_e.mis = 1'b1;
                        mq.push_back(m_e);
                    end
                end else if (rvalid) begin
                    if (m_out == 1) begin
                        m_e.instr = rdata; m_e.pc = m_pc; m_e.mis = 1'b0;
                        mq.push_back(m_e);
                    end
                    m_out = 0;
                end
                if (mq.size() > 2) chk("model_overflow", mq.size(), 2);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_instr_valid", instr_valid, (mq.size() != 0));
            if (mq.size() != 0) begin
                chk("cyc_instr", instr, mq[0].instr);
                chk("cyc_instr_pc", instr_pc, mq[0].pc);
                chk("cyc_misalign", misalign, mq[0].mis);
            end
`ifndef FETCH_ALIGN_CHECK_EN
            chk("cyc_misalign_tied", misalign, 1'b0);
`endif
            chk("cyc_mem_req", mem_req, exp_req());
            if (exp_req()) chk("cyc_mem_addr", mem_addr, exp_addr());
            chk("cyc_pc_ready", pc_ready, exp_rdy());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [9:0] a, input logic [31:0] d);
        pc_valid = 1'b1; pc = a; gnt = 1'b1;
        tick();
        pc_valid = 1'b0; gnt = 1'b0; rvalid = 1'b1; rdata = d;
        tick();
        rvalid = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 10'h0);
        chk("rst_misalign", misalign, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        rst_n = 1'b1;
        tick();

        // best-case latency
        instr_ready = 1'b1;
        pc_valid = 1'b1; pc = 10'h000; gnt = 1'b1;
        #1;
        chk("t1_req", mem_req, 1'b1);
        chk("t1_rdy", pc_ready, 1'b1);
        tick();
        pc_valid = 1'b0; gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0050_0093;
        chk("t1_not_yet", instr_valid, 1'b0);
        tick();
        rvalid = 1'b0;
        chk("t1_valid", instr_valid, 1'b1);
        chk("t1_instr", instr, 32'h0050_0093);
        chk("t1_pc", instr_pc, 10'h000);
        tick();
        chk("t1_popped", instr_valid, 1'b0);

        // FIFO full back-pressure
        instr_ready = 1'b0;
        fetch(10'h000, 32'h1111_1111);
        fetch(10'h004, 32'h2222_2222);
        pc_valid = 1'b1; pc = 10'h008; gnt = 1'b1;
        #1;
        chk("t2_full_req", mem_req, 1'b0);
        chk("t2_full_rdy", pc_ready, 1'b0);
        chk("t2_head", instr, 32'h1111_1111);
        tick();
        tick();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        #1;
        chk("t2_req_after_pop", mem_req, 1'b1);
        chk("t2_rdy_after_pop", pc_ready, 1'b1);
        tick();
        pc_valid = 1'b0; gnt = 1'b0; rvalid = 1'b1; rdata = 32'h3333_3333;
        tick();
        rvalid = 1'b0;
        chk("t2_head_b", instr, 32'h2222_2222);
        chk("t2_head_b_pc", instr_pc, 10'h004);
        instr_ready = 1'b1;
        tick();
        chk("t2_head_c", instr, 32'h3333_3333);
        chk("t2_head_c_pc", instr_pc, 10'h008);
        tick();
        chk("t2_drained", instr_valid, 1'b0);

        // grant withheld
        pc_valid = 1'b1; pc = 10'h040; gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_req_held", mem_req, 1'b1);
            chk("t3_addr_held", mem_addr, 10'h040);
            chk("t3_rdy_low", pc_ready, 1'b0);
            chk("t3_fifo_empty", instr_valid, 1'b0);
            tick();
        end
        gnt = 1'b1;
        tick();
        pc_valid = 1'b0; gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0BAD_C0DE;
        tick();
        rvalid = 1'b0;
        chk("t3_instr", instr, 32'h0BAD_C0DE);
        tick();

        // flush while WAIT, stale data arrives two cycles later
        pc_valid = 1'b1; pc = 10'h080; gnt = 1'b1;
        tick();
        pc_valid = 1'b0; gnt = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        tick();
        rvalid = 1'b0;
        chk("t4_dropped", instr_valid, 1'b0);
        tick();
        chk("t4_still_empty", instr_valid, 1'b0);
        fetch(10'h100, 32'h00A0_0113);
        chk("t4_new_instr", instr, 32'h00A0_0113);
        chk("t4_new_pc", instr_pc, 10'h100);
        tick();

        // flush with two buffered entries and a simultaneous pop
        instr_ready = 1'b0;
        fetch(10'h010, 32'hAAAA_0001);
        fetch(10'h014, 32'hAAAA_0002);
        flush = 1'b1; instr_ready = 1'b1; pc_valid = 1'b1; pc = 10'h020; gnt = 1'b1;
        #1;
        chk("t5_flush_rdy", pc_ready, 1'b0);
        chk("t5_flush_req", mem_req, 1'b0);
        tick();
        flush = 1'b0;
        chk("t5_cleared", instr_valid, 1'b0);
        #1;
        chk("t5_refetch_rdy", pc_ready, 1'b1);
        tick();
        pc_valid = 1'b0; gnt = 1'b0; rvalid = 1'b1; rdata = 32'hAAAA_0003;
        tick();
        rvalid = 1'b0;
        chk("t5_new_instr", instr, 32'hAAAA_0003);
        chk("t5_new_pc", instr_pc, 10'h020);
        tick();

        // flush and rvalid in the same WAIT cycle
        pc_valid = 1'b1; pc = 10'h030; gnt = 1'b1;
        tick();
        pc_valid = 1'b0; gnt = 1'b0; flush = 1'b1; rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
        tick();
        flush = 1'b0; rvalid = 1'b0;
        chk("t6_dropped", instr_valid, 1'b0);
        pc_valid = 1'b1; pc = 10'h034; gnt = 1'b1;
        #1;
        chk("t6_idle_req", mem_req, 1'b1);
        tick();
        pc_valid = 1'b0; gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0000_6666;
        tick();
        rvalid = 1'b0;
        chk("t6_instr", instr, 32'h0000_6666);
        tick();

        // asynchronous reset mid-WAIT, late rvalid ignored
        instr_ready = 1'b0;
        fetch(10'h048, 32'h7777_7777);
        pc_valid = 1'b1; pc = 10'h044; gnt = 1'b1;
        tick();
        pc_valid = 1'b0; gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_valid", instr_valid, 1'b0);
        chk("t7_rst_instr", instr, 32'h0);
        tick();
        rst_n = 1'b1;
        rvalid = 1'b1; rdata = 32'h5555_5555;
        tick();
        rvalid = 1'b0;
        chk("t7_late_ignored", instr_valid, 1'b0);
        instr_ready = 1'b1;
        tick();

        // back-to-back stream, one instruction per two cycles
        for (int i = 0; i < 5; i++) begin
            fetch(10'h200 + 10'(4 * i), 32'h1000_0000 + i);
            chk("t8_instr", instr, 32'h1000_0000 + i);
            chk("t8_pc", instr_pc, 10'h200 + 10'(4 * i));
        end
        tick();
        chk("t8_drained", instr_valid, 1'b0);

`ifdef FETCH_ALIGN_CHECK_EN
        instr_ready = 1'b0;
        pc_valid = 1'b1; pc = 10'h006; gnt = 1'b0;
        #1;
        chk("t9_no_req", mem_req, 1'b0);
        chk("t9_rdy", pc_ready, 1'b1);
        tick();
        pc_valid = 1'b0;
        chk("t9_nop", instr, NOP);
        chk("t9_pc", instr_pc, 10'h006);
        chk("t9_mis", misalign, 1'b1);
        instr_ready = 1'b1;
        tick();
`else
        pc_valid = 1'b1; pc = 10'h0A2; gnt = 1'b1;
        #1;
        chk("t9_masked_addr", mem_addr, 10'h0A0);
        tick();
        pc_valid = 1'b0; gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0A0A;
        tick();
        rvalid = 1'b0;
        chk("t9_masked_pc", instr_pc, 10'h0A0);
        chk("t9_mis_zero", misalign, 1'b0);
        tick();
`endif

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage between the program counter and instruction decode. Accepts a fetch address from the PC stage, issues one read at a time to instruction memory, and buffers returned words in a 2-entry FIFO. Decode consumes them over a valid/ready handshake. A flush on taken branches/jumps discards in-flight and buffered fetches so the redirected stream starts clean.

## Interface
Parameters:
- MEM_ADDR_WIDTH, 10, byte-address width, same as PC stage
- INSTR_WIDTH, 32, instruction word width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- pc_i  in  MEM_ADDR_WIDTH  fetch byte address from PC stage
- pc_valid_i  in  1  pc_i is valid
- pc_ready_o  out  1  fetch accepts pc_i this cycle (also PC-stage stall, active low)
- flush_i  in  1  discard outstanding and buffered fetches
- mem_req_o  out  1  memory read request
- mem_addr_o  out  MEM_ADDR_WIDTH  memory read address
- mem_gnt_i  in  1  memory accepts request this cycle
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  INSTR_WIDTH  read data
- instr_o  out  INSTR_WIDTH  instruction at FIFO head
- instr_pc_o  out  MEM_ADDR_WIDTH  address of instr_o
- instr_valid_o  out  1  FIFO head valid
- instr_ready_i  in  1  decode consumes head
- misalign_o  out  1  head entry came from misaligned address

## Operation
- FSM states: IDLE (no outstanding read), WAIT (read granted, awaiting rvalid), DROP (flushed read awaiting rvalid, to be discarded).
- pc_ready_o = state==IDLE && !flush_i && (fifo_count + 0) < 2 && (mem_gnt_i || misaligned path); combinational.
- mem_req_o = pc_valid_i && state==IDLE && !flush_i && fifo_count<2; mem_addr_o = pc_i. Request stays asserted until mem_gnt_i.
- Grant: IDLE->WAIT, pc_i latched as entry address.
- WAIT, mem_rvalid_i: push {mem_rdata_i, latched pc, misalign=0}; ->IDLE. A new request may issue in that IDLE cycle onward only.
- Pop when instr_valid_o && instr_ready_i. Push and pop in same cycle allowed; count unchanged.
- flush_i: FIFO cleared next edge; WAIT->DROP (or WAIT->IDLE if mem_rvalid_i same cycle, data dropped); DROP + mem_rvalid_i -> IDLE, data dropped. No push while flush_i or in DROP.
- At most one outstanding read; reservation guarantees FIFO never overflows.
- Reset: state IDLE, FIFO empty, instr_valid_o=0, instr_o=0, instr_pc_o=0, misalign_o=0, mem_req_o=0.

## Timing
- FIFO outputs registered; pushed entry visible on instr_* one cycle after the push edge.
- Best case: request granted cycle N, rvalid N+1, instr_valid_o N+2.
- Throughput: one instruction per 2 cycles with 1-cycle memory (single outstanding).
- Flush in cycle N: instr_valid_o=0 from N+1; pc_ready_o=0 in N; new fetch accepted N+1 if IDLE.
- Reset mid-WAIT: asynchronous return to IDLE; late mem_rvalid_i after reset is ignored (state IDLE).

## Configuration
- FETCH_ALIGN_CHECK_EN defined: pc_i[1:0]!=0 with pc_valid_i in IDLE issues no memory request; pc_ready_o=1 if FIFO has space; pushes {32'h00000013 (NOP), pc_i, misalign=1} directly; misalign_o reflects head flag.
- Undefined: pc_i[1:0] ignored, mem_addr_o[1:0] forced 0, misalign_o tied 0.

## Test plan
- Reset then pc_i=0x000 valid, gnt same cycle, rvalid next cycle rdata=0x00500093 -> instr_valid_o=1 two cycles after grant, instr_o=0x00500093, instr_pc_o=0x000.
- instr_ready_i=0, fetch 0x000,0x004,0x008 -> two entries buffered, mem_req_o=0 and pc_ready_o=0 for third until one pop.
- mem_gnt_i held 0 for 3 cycles -> mem_req_o and mem_addr_o stable, pc_ready_o=0, no FIFO change.
- Flush while WAIT, rvalid arrives 2 cycles later with 0xDEADBEEF -> never appears on instr_o; next fetch 0x100 delivers its own data.
- Flush with 2 buffered entries and simultaneous pop -> instr_valid_o=0 next cycle.
- FETCH_ALIGN_CHECK_EN, pc_i=0x006 -> no mem_req_o, instr_o=0x00000013, instr_pc_o=0x006, misalign_o=1 next cycle.
